// File: rtl/spike_dispatcher.sv
// Spike ingress stage: buffers {origin, destination} packets, maps destinations to local
// neurons and delivers origin addresses, dropping out-of-range or stalled packets.
//
// state | meaning
// EMPTY | no packet buffered
// HEAD  | head entry valid; decided every cycle (range drop, deliver, or stall/timeout)
module spike_dispatcher #(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_W      = 12,
  parameter int FIFO_DEPTH  = 8,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 16
) (
  input  logic                          CLK,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2*ADDR_W-1:0]           in_packet,
  input  logic [NUM_NEURONS-1:0]        neuron_ready,
  output logic [ADDR_W*NUM_NEURONS-1:0] src_addr,
  output logic [NUM_NEURONS-1:0]        src_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic [CNT_W-1:0]              range_drops,
  output logic [CNT_W-1:0]              timeout_drops
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int STL_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] NUM_LOCAL  = ADDR_W'(NUM_NEURONS);
  localparam logic [STL_W-1:0]  STALL_LAST = STL_W'(TIMEOUT - 1);
  localparam logic [LVL_W-1:0]  DEPTH_LVL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic {EMPTY, HEAD} state_t;

  state_t                state;
  logic [2*ADDR_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [STL_W-1:0]      stall_cnt;

  logic [2*ADDR_W-1:0]   head;
  logic [ADDR_W-1:0]     head_origin;
  logic [ADDR_W-1:0]     head_dest;
  logic [ADDR_W:0]       diff;
  logic [ADDR_W-1:0]     idx;
  logic                  in_range;
  logic [NUM_NEURONS-1:0] head_oh;
  logic                  head_ready;
  logic                  push;
  logic                  pop;
  logic                  deliver;
  logic                  range_drop;
  logic                  timeout_drop;
  logic [LVL_W-1:0]      level_next;

  // Borrow out of the widened subtraction flags destinations below the base.
  always_comb begin
    head         = mem[rd_ptr];
    head_origin  = head[2*ADDR_W-1:ADDR_W];
    head_dest    = head[ADDR_W-1:0];
    diff         = {1'b0, head_dest} - {1'b0, BASE};
    idx          = diff[ADDR_W-1:0];
    in_range     = !diff[ADDR_W] && (idx < NUM_LOCAL);
    head_oh      = in_range ? (NUM_NEURONS'(1) << idx) : '0;
    head_ready   = |(neuron_ready & head_oh);
    push         = in_valid && in_ready;
    pop          = 1'b0;
    deliver      = 1'b0;
    range_drop   = 1'b0;
    timeout_drop = 1'b0;
    if (state == HEAD) begin
      if (!in_range) begin
        pop        = 1'b1;
        range_drop = 1'b1;
      end else if (head_ready) begin
        pop     = 1'b1;
        deliver = 1'b1;
      end else if (stall_cnt == STALL_LAST) begin
        pop          = 1'b1;
        timeout_drop = 1'b1;
      end
    end
    level_next = fifo_level;
    if (push && !pop) begin
      level_next = fifo_level + LVL_W'(1);
    end else if (pop && !push) begin
      level_next = fifo_level - LVL_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= in_packet;
    end
  end

  always_ff @(posedge CLK) begin
    if (!clear) begin
      state         <= EMPTY;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      in_ready      <= 1'b0;
      stall_cnt     <= '0;
      src_addr      <= '0;
      src_valid     <= '0;
      range_drops   <= '0;
      timeout_drops <= '0;
    end else begin
      fifo_level <= level_next;
      in_ready   <= (level_next < DEPTH_LVL);
      state      <= (level_next != '0) ? HEAD : EMPTY;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        stall_cnt <= '0;
      end else if (state == HEAD) begin
        stall_cnt <= stall_cnt + STL_W'(1);
      end
      src_valid <= deliver ? head_oh : '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (deliver && head_oh[i]) begin
          src_addr[i*ADDR_W +: ADDR_W] <= head_origin;
        end
      end
      if (range_drop && (range_drops != '1)) begin
        range_drops <= range_drops + CNT_W'(1);
      end
      if (timeout_drop && (timeout_drops != '1)) begin
        timeout_drops <= timeout_drops + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spike_dispatcher.sv
// Bench for spike_dispatcher: two instances (base 0 / wide counters, base 16 / 2-bit
// counters) share stimulus and are checked every cycle against a queue-based model.
module tb_spike_dispatcher;

  localparam int NN = 10;
  localparam int AW = 12;
  localparam int DEPTH = 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              clear;
  logic              in_valid;
  logic [2*AW-1:0]   in_packet;
  logic [NN-1:0]     neuron_ready;

  logic              ir0, ir1;
  logic [AW*NN-1:0]  sa0, sa1;
  logic [NN-1:0]     sv0, sv1;
  logic [3:0]        lvl0, lvl1;
  logic [15:0]       rd0, td0;
  logic [1:0]        rd1, td1;

  int checks = 0;
  int errors = 0;

  // model state, index 0 = base 0 / 16-bit counters, 1 = base 16 / 2-bit counters
  logic [2*AW-1:0] mq [2][DEPTH];
  int              mcnt [2];
  int              mstall [2];
  int              mrange [2];
  int              mtime [2];
  logic [AW-1:0]   msrc [2][NN];
  logic [NN-1:0]   msv [2];
  logic            mready [2];
  int              mbase [2] = '{0, 16};
  int              mmax [2] = '{65535, 3};

  always #5 clk = ~clk;

  spike_dispatcher #(.NUM_NEURONS(NN), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .BASE_ADDR(0),
                     .TIMEOUT(TO), .CNT_W(16)) dut0 (
    .CLK(clk), .clear(clear), .in_valid(in_valid), .in_ready(ir0), .in_packet(in_packet),
    .neuron_ready(neuron_ready), .src_addr(sa0), .src_valid(sv0), .fifo_level(lvl0),
    .range_drops(rd0), .timeout_drops(td0));

  spike_dispatcher #(.NUM_NEURONS(NN), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .BASE_ADDR(16),
                     .TIMEOUT(TO), .CNT_W(2)) dut1 (
    .CLK(clk), .clear(clear), .in_valid(in_valid), .in_ready(ir1), .in_packet(in_packet),
    .neuron_ready(neuron_ready), .src_addr(sa1), .src_valid(sv1), .fifo_level(lvl1),
    .range_drops(rd1), .timeout_drops(td1));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the reference: decide on the head as it stands, then append the push.
  task automatic model_cycle(input int u);
    logic [2*AW-1:0] p;
    logic [NN-1:0]   sv;
    int              d;
    int              idx;
    bit              popped;
    bit              acc;
    if (!clear) begin
      mcnt[u] = 0; mstall[u] = 0; mrange[u] = 0; mtime[u] = 0;
      msv[u] = '0; mready[u] = 1'b0;
      for (int i = 0; i < NN; i++) msrc[u][i] = '0;
      return;
    end
    acc = in_valid && mready[u];
    sv = '0;
    popped = 1'b0;
    if (mcnt[u] > 0) begin
      p = mq[u][0];
      d = int'(p[AW-1:0]);
      if (d < mbase[u] || d - mbase[u] >= NN) begin
        popped = 1'b1;
        if (mrange[u] < mmax[u]) mrange[u]++;
      end else begin
        idx = d - mbase[u];
        if (neuron_ready[idx]) begin
          popped = 1'b1;
          msrc[u][idx] = p[2*AW-1:AW];
          sv[idx] = 1'b1;
        end else begin
          mstall[u]++;
          if (mstall[u] == TO) begin
            popped = 1'b1;
            if (mtime[u] < mmax[u]) mtime[u]++;
          end
        end
      end
      if (popped) begin
        for (int k = 0; k < DEPTH - 1; k++) mq[u][k] = mq[u][k+1];
        mcnt[u]--;
        mstall[u] = 0;
      end
    end
    if (acc) begin
      mq[u][mcnt[u]] = in_packet;
      mcnt[u]++;
    end
    msv[u] = sv;
    mready[u] = (mcnt[u] < DEPTH);
  endtask

  task automatic cmp_unit(input int u, input logic ir, input logic [3:0] lvl,
                          input logic [NN-1:0] sv, input logic [AW*NN-1:0] sa,
                          input logic [15:0] rd, input logic [15:0] td);
    logic [AW*NN-1:0] esa;
    for (int i = 0; i < NN; i++) esa[i*AW +: AW] = msrc[u][i];
    chk($sformatf("u%0d in_ready", u), 128'(ir), 128'(mready[u]));
    chk($sformatf("u%0d fifo_level", u), 128'(lvl), 128'(mcnt[u]));
    chk($sformatf("u%0d src_valid", u), 128'(sv), 128'(msv[u]));
    chk($sformatf("u%0d src_addr", u), 128'(sa), 128'(esa));
    chk($sformatf("u%0d range_drops", u), 128'(rd), 128'(mrange[u]));
    chk($sformatf("u%0d timeout_drops", u), 128'(td), 128'(mtime[u]));
  endtask

  task automatic step();
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    #1;
    cmp_unit(0, ir0, lvl0, sv0, sa0, rd0, td0);
    cmp_unit(1, ir1, lvl1, sv1, sa1, {14'b0, rd1}, {14'b0, td1});
  endtask

  task automatic push(input logic [AW-1:0] org, input logic [AW-1:0] dst);
    in_valid = 1'b1;
    in_packet = {org, dst};
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    step();
    clear = 1'b1;
    step();
  endtask

  initial begin
    int strobes;
    int pct;
    clear = 1'b0;
    in_valid = 1'b0;
    in_packet = '0;
    neuron_ready = '1;

    // reset / idle
    repeat (3) step();
    chk("rst in_ready low", 128'(ir0), 128'(0));
    clear = 1'b1;
    step();
    chk("idle in_ready", 128'(ir0), 128'(1));
    chk("idle level", 128'(lvl0), 128'(0));
    chk("idle src_addr", 128'(sa0), 128'(0));

    // single delivery
    push(12'h05A, 12'd3);
    step();
    chk("single strobe", 128'(sv0), 128'(10'b0000001000));
    chk("single slice3", 128'(sa0[3*AW +: AW]), 128'(12'h05A));
    chk("single level", 128'(lvl0), 128'(0));
    step();
    chk("single strobe one cycle", 128'(sv0), 128'(0));

    // backpressure / full
    neuron_ready = '0;
    for (int k = 0; k < 8; k++) push(12'h100 + 12'(k), 12'd1);
    chk("full level", 128'(lvl0), 128'(8));
    chk("full in_ready", 128'(ir0), 128'(0));
    push(12'h1FF, 12'd1);
    chk("full no accept", 128'(lvl0), 128'(8));
    chk("u1 range sat", 128'(rd1), 128'(3));
    neuron_ready = 10'b0000000010;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("drain strobe", 128'(sv0), 128'(10'b0000000010));
      chk("drain order", 128'(sa0[AW +: AW]), 128'(12'h100 + 12'(k)));
    end
    step();
    chk("drain empty", 128'(lvl0), 128'(0));

    // range drop (unit 1, base 16)
    neuron_ready = '1;
    do_reset();
    push(12'h0A1, 12'd10);
    push(12'h0A2, 12'd30);
    push(12'h0A3, 12'd20);
    strobes = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      strobes += $countones(sv1);
    end
    chk("range drops u1", 128'(rd1), 128'(2));
    chk("range drops u0", 128'(rd0), 128'(3));
    chk("range strobes", 128'(strobes), 128'(1));
    chk("range slice4", 128'(sa1[4*AW +: AW]), 128'(12'h0A3));

    // timeout drop
    do_reset();
    neuron_ready = 10'b1111111011;
    push(12'h0B2, 12'd2);
    push(12'h0B5, 12'd5);
    repeat (14) step();
    chk("timeout not yet", 128'(td0), 128'(0));
    step();
    chk("timeout drop", 128'(td0), 128'(1));
    chk("timeout no strobe", 128'(sv0), 128'(0));
    step();
    chk("after timeout strobe", 128'(sv0), 128'(10'b0000100000));
    chk("after timeout slice5", 128'(sa0[5*AW +: AW]), 128'(12'h0B5));

    // ready on the last stall cycle wins
    do_reset();
    neuron_ready = 10'b1111111011;
    push(12'h0C2, 12'd2);
    repeat (15) step();
    neuron_ready = '1;
    step();
    chk("boundary strobe", 128'(sv0), 128'(10'b0000000100));
    chk("boundary no drop", 128'(td0), 128'(0));
    chk("boundary slice2", 128'(sa0[2*AW +: AW]), 128'(12'h0C2));

    // reset mid-operation
    neuron_ready = '0;
    for (int k = 0; k < 5; k++) push(12'h0D0 + 12'(k), 12'(k));
    chk("mid queued", 128'(lvl0), 128'(5));
    clear = 1'b0;
    step();
    clear = 1'b1;
    chk("mid level", 128'(lvl0), 128'(0));
    neuron_ready = '1;
    strobes = 0;
    repeat (3) begin
      step();
      strobes += $countones(sv0);
    end
    chk("mid no strobes", 128'(strobes), 128'(0));
    chk("mid counters", 128'({rd0, td0}), 128'(0));

    // randomized traffic
    for (int blk = 0; blk < 8; blk++) begin
      pct = (blk % 3 == 0) ? 8 : ((blk % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 100; c++) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_packet = {12'($urandom), 12'($urandom_range(0, 31))};
        for (int i = 0; i < NN; i++) neuron_ready[i] = ($urandom_range(0, 99) < pct);
        clear = ($urandom_range(0, 149) != 0);
        step();
      end
    end
    clear = 1'b1;
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
